// File: rtl/stopwatch_pkg.sv
// Shared constants for the MM:SS stopwatch core: state encoding, counter limits and widths.
package stopwatch_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 7;

    localparam int SEC_MAX_DEF = 59;
    localparam int MIN_MAX_DEF = 99;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

endpackage

// File: rtl/stopwatch_upcounter.sv
// Modulo up-counter 0..MAX with synchronous clear and a combinational terminal-count carry.
module upcounter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count_en,
    input  logic             clear,
    output logic [WIDTH-1:0] binary,
    output logic             carry
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    assign carry = count_en && (binary == MAX_V);

    // Count register: clear wins, then wrap at MAX, otherwise increment on enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binary <= '0;
        end else if (clear) begin
            binary <= '0;
        end else if (count_en) begin
            if (binary == MAX_V) begin
                binary <= '0;
            end else begin
                binary <= binary + ONE_V;
            end
        end else begin
            binary <= binary;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: start/pause/lap/clear FSM driving chained seconds/minutes counters,
// with a lap freeze register, sticky overflow flag and display mux.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int SEC_MAX = SEC_MAX_DEF,
    parameter int MIN_MAX = MIN_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_en,
    input  logic             start_pause,
    input  logic             lap,
    input  logic             clear,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [SEC_W-1:0] disp_sec,
    output logic [MIN_W-1:0] disp_min,
    output logic             running,
    output logic             lap_active,
    output logic             overflow
);

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic             count_en_s;
    logic             sec_carry_s;
    logic             min_carry_s;
    logic             clear_s;
    logic             lap_cap_s;
    logic [SEC_W-1:0] lap_sec_r;
    logic [MIN_W-1:0] lap_min_r;
    logic             overflow_r;

    assign count_en_s = tick_en && ((state_r == ST_RUN) || (state_r == ST_LAP));
    // Only PAUSE honours clear; elsewhere the pulse is dropped.
    assign clear_s    = (state_r == ST_PAUSE) && clear;
    assign lap_cap_s  = (state_r == ST_RUN) && !start_pause && lap;

    upcounter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (count_en_s),
        .clear    (clear_s),
        .binary   (sec),
        .carry    (sec_carry_s)
    );

    upcounter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (sec_carry_s),
        .clear    (clear_s),
        .binary   (min),
        .carry    (min_carry_s)
    );

    // Next-state decode with clear > start_pause > lap priority inside each state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_pause) next_state_s = ST_RUN;
                else             next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (start_pause) next_state_s = ST_PAUSE;
                else if (lap)    next_state_s = ST_LAP;
                else             next_state_s = ST_RUN;
            end
            ST_LAP: begin
                if (start_pause) next_state_s = ST_PAUSE;
                else if (lap)    next_state_s = ST_RUN;
                else             next_state_s = ST_LAP;
            end
            ST_PAUSE: begin
                if (clear)            next_state_s = ST_IDLE;
                else if (start_pause) next_state_s = ST_RUN;
                else                  next_state_s = ST_PAUSE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Lap register captures the pre-increment live value; sticky overflow set on full wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_sec_r  <= '0;
            lap_min_r  <= '0;
            overflow_r <= 1'b0;
        end else if (clear_s) begin
            lap_sec_r  <= '0;
            lap_min_r  <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (lap_cap_s) begin
                lap_sec_r <= sec;
                lap_min_r <= min;
            end else begin
                lap_sec_r <= lap_sec_r;
                lap_min_r <= lap_min_r;
            end
            overflow_r <= overflow_r | min_carry_s;
        end
    end

    // Display mux: frozen lap value while in LAP, live value otherwise.
    always_comb begin
        disp_sec = sec;
        disp_min = min;
        if (state_r == ST_LAP) begin
            disp_sec = lap_sec_r;
            disp_min = lap_min_r;
        end else begin
            disp_sec = sec;
            disp_min = min;
        end
    end

    assign running    = (state_r == ST_RUN) || (state_r == ST_LAP);
    assign lap_active = (state_r == ST_LAP);
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: vector table plus hand-written multi-cycle sequences.
module tb_stopwatch_counter;

    logic       clk;
    logic       rst_n;
    logic       tick_en;
    logic       start_pause;
    logic       lap;
    logic       clear;
    logic [5:0] sec;
    logic [6:0] min;
    logic [5:0] disp_sec;
    logic [6:0] disp_min;
    logic       running;
    logic       lap_active;
    logic       overflow;

    int n_vec;
    int n_err;

    typedef struct {
        logic       t, s, l, c;
        logic [5:0] es;
        logic [6:0] em;
        logic [5:0] eds;
        logic [6:0] edm;
        logic       er, el, eo;
    } vec_t;

    vec_t vecs[26];

    stopwatch_counter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_en     (tick_en),
        .start_pause (start_pause),
        .lap         (lap),
        .clear       (clear),
        .sec         (sec),
        .min         (min),
        .disp_sec    (disp_sec),
        .disp_min    (disp_min),
        .running     (running),
        .lap_active  (lap_active),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] es, input logic [6:0] em,
                         input logic [5:0] eds, input logic [6:0] edm,
                         input logic er, input logic el, input logic eo);
        n_vec++;
        if (sec !== es || min !== em || disp_sec !== eds || disp_min !== edm ||
            running !== er || lap_active !== el || overflow !== eo) begin
            n_err++;
            $display("FAIL %s: got sec=%0d min=%0d dsec=%0d dmin=%0d run=%b lap=%b ov=%b, want sec=%0d min=%0d dsec=%0d dmin=%0d run=%b lap=%b ov=%b",
                     name, sec, min, disp_sec, disp_min, running, lap_active, overflow,
                     es, em, eds, edm, er, el, eo);
        end
    endtask

    // Drive one cycle of pulses at the falling edge; return 1 ns after the rising edge.
    task automatic step(input logic t, input logic s, input logic l, input logic c);
        @(negedge clk);
        tick_en = t; start_pause = s; lap = l; clear = c;
        @(posedge clk);
        #1;
        tick_en = 1'b0; start_pause = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; tick_en = 1'b0; start_pause = 1'b0; lap = 1'b0; clear = 1'b0;

        //           t     s     l     c     sec    min    dsec   dmin   run   lap   ov
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  7'd0,  6'd0,  7'd0,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  7'd0,  6'd0,  7'd0,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  7'd0,  6'd0,  7'd0,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  7'd0,  6'd0,  7'd0,  1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd1,  7'd0,  6'd1,  7'd0,  1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd2,  7'd0,  6'd2,  7'd0,  1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd3,  7'd0,  6'd2,  7'd0,  1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd4,  7'd0,  6'd2,  7'd0,  1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd4,  7'd0,  6'd2,  7'd0,  1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd4,  7'd0,  6'd4,  7'd0,  1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd5,  7'd0,  6'd5,  7'd0,  1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd5,  7'd0,  6'd5,  7'd0,  1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd6,  7'd0,  6'd6,  7'd0,  1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd6,  7'd0,  6'd6,  7'd0,  1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd6,  7'd0,  6'd6,  7'd0,  1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  7'd0,  6'd0,  7'd0,  1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  7'd0,  6'd0,  7'd0,  1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'd1,  7'd0,  6'd1,  7'd0,  1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd0,  7'd0,  6'd0,  7'd0,  1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  7'd0,  6'd0,  7'd0,  1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd1,  7'd0,  6'd1,  7'd0,  1'b1, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd1,  7'd0,  6'd1,  7'd0,  1'b1, 1'b1, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd2,  7'd0,  6'd1,  7'd0,  1'b1, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd2,  7'd0,  6'd2,  7'd0,  1'b0, 1'b0, 1'b0};
        vecs[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd2,  7'd0,  6'd2,  7'd0,  1'b0, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  7'd0,  6'd0,  7'd0,  1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset", 6'd0, 7'd0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step(vecs[i].t, vecs[i].s, vecs[i].l, vecs[i].c);
            check($sformatf("vec%0d", i), vecs[i].es, vecs[i].em, vecs[i].eds, vecs[i].edm,
                  vecs[i].er, vecs[i].el, vecs[i].eo);
        end

        // Minute rollover, then full wrap to 00:00 with overflow, then clear.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(59);
        check("at_00_59", 6'd59, 7'd0, 6'd59, 7'd0, 1'b1, 1'b0, 1'b0);
        ticks(2);
        check("at_01_01", 6'd1, 7'd1, 6'd1, 7'd1, 1'b1, 1'b0, 1'b0);
        ticks(5938);
        check("at_99_59", 6'd59, 7'd99, 6'd59, 7'd99, 1'b1, 1'b0, 1'b0);
        ticks(1);
        check("wrap", 6'd0, 7'd0, 6'd0, 7'd0, 1'b1, 1'b0, 1'b1);
        ticks(1);
        check("post_wrap", 6'd1, 7'd0, 6'd1, 7'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("pause_keeps_ov", 6'd1, 7'd0, 6'd1, 7'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("clear_ov", 6'd0, 7'd0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        // Lap freeze and release back to live display.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_enter", 6'd10, 7'd0, 6'd10, 7'd0, 1'b1, 1'b1, 1'b0);
        ticks(5);
        check("lap_frozen", 6'd15, 7'd0, 6'd10, 7'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_exit", 6'd15, 7'd0, 6'd15, 7'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap_cleared", 6'd0, 7'd0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges while in LAP at 03:21.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(201);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("at_03_21_lap", 6'd21, 7'd3, 6'd21, 7'd3, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 6'd0, 7'd0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);
        check("no_count_after_reset", 6'd0, 7'd0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(2);
        check("restart", 6'd2, 7'd0, 6'd2, 7'd0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
